alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the 16-bit ALU.
- Holds the 8-entry general register file and accepts decoded instructions (opcode, rd, rs, rt) over a valid/ready handshake.
- Reads and forwards operands, then presents a registered x/y/opcode/rd bundle to the ALU.
- Tracks pending writes with a scoreboard and stalls read-after-write hazards until the ALU result is written back.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/regfile_2r1w.sv | 47 ++++
 rtl/alu_operand_stage.sv | 124 ++++++++++++
 tb/tb_alu_operand_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and datapath defaults for the ALU issue path.
package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;
  localparam int DEF_AW    = 3;
  localparam int OPW       = 3;

  localparam logic [OPW-1:0] OP_AND = 3'b000;
  localparam logic [OPW-1:0] OP_OR  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD = 3'b010;
  localparam logic [OPW-1:0] OP_SUB = 3'b110;
  localparam logic [OPW-1:0] OP_SLT = 3'b111;

  // 011, 100 and 101 are unassigned and rejected at issue
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: two combinational read ports, one clocked write port.
// Register 0 is hardwired to zero; a write in the same cycle as a read of the
// same address is bypassed straight to the read port.
module regfile_2r1w #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // storage update; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // read port a with write-through bypass
  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != '0) begin
      rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    end
  end

  // read port b with write-through bypass
  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != '0) begin
      rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU: register read with writeback forwarding,
// pending-write scoreboard for RAW stalls, and a one-deep output bundle.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [OPW-1:0]   out_opcode,
  output logic [AW-1:0]    out_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             illegal_op
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_x_q, out_x_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [OPW-1:0]   out_opcode_q, out_opcode_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic             illegal_op_q, illegal_op_d;
  logic [NREGS-1:0] pending_q, pending_d;

  logic [WIDTH-1:0] rd_x, rd_y;
  logic             legal, wb_live, pend_rs, pend_rt, hazard, out_free, accept;

  regfile_2r1w #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (in_rs),
    .rdata_a_o (rd_x),
    .raddr_b_i (in_rt),
    .rdata_b_o (rd_y)
  );

  // hazard detection: a source being written back this cycle is forwarded, not stalled
  always_comb begin
    legal    = is_legal_op(in_opcode);
    wb_live  = wb_en && (wb_addr != '0);
    pend_rs  = (in_rs != '0) && pending_q[in_rs] && !(wb_live && (wb_addr == in_rs));
    pend_rt  = (in_rt != '0) && pending_q[in_rt] && !(wb_live && (wb_addr == in_rt));
    hazard   = in_valid && legal && (pend_rs || pend_rt);
    out_free = !out_valid_q || out_ready;
    in_ready = out_free && !hazard;
    accept   = in_valid && in_ready;
  end

  // next bundle, illegal pulse and scoreboard; a set on the same bit beats the clear
  always_comb begin
    out_valid_d  = out_valid_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_opcode_d = out_opcode_q;
    out_rd_d     = out_rd_q;
    illegal_op_d = 1'b0;
    pending_d    = pending_q;

    if (wb_live) pending_d[wb_addr] = 1'b0;

    if (accept && legal) begin
      out_valid_d  = 1'b1;
      out_x_d      = rd_x;
      out_y_d      = rd_y;
      out_opcode_d = in_opcode;
      out_rd_d     = in_rd;
      if (in_rd != '0) pending_d[in_rd] = 1'b1;
    end else if (accept) begin
      out_valid_d  = 1'b0;
      illegal_op_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_opcode_q <= '0;
      out_rd_q     <= '0;
      illegal_op_q <= 1'b0;
      pending_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_opcode_q <= out_opcode_d;
      out_rd_q     <= out_rd_d;
      illegal_op_q <= illegal_op_d;
      pending_q    <= pending_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_opcode = out_opcode_q;
  assign out_rd     = out_rd_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode;
  logic [2:0]  in_rd, in_rs, in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x, out_y;
  logic [2:0]  out_opcode;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [2:0] op, input logic [2:0] rd);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".x"}, 32'(out_x), 32'(x));
    chk({tag, ".y"}, 32'(out_y), 32'(y));
    chk({tag, ".op"}, 32'(out_opcode), 32'(op));
    chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // reset state
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.x", 32'(out_x), 32'd0);
    chk("rst.y", 32'(out_y), 32'd0);
    chk("rst.op", 32'(out_opcode), 32'd0);
    chk("rst.rd", 32'(out_rd), 32'd0);
    chk("rst.illegal", 32'(illegal_op), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // load r1=5, r2=3 then ADD r3 = r1 + r2
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005;
    step();
    wb_addr = 3'd2; wb_data = 16'h0003;
    step();
    wb_en = 1'b0;
    issue(3'b010, 3'd3, 3'd1, 3'd2);
    #1 chk("add.in_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("add", 16'h0005, 16'h0003, 3'b010, 3'd3);

    // dependent SUB stalls on r3 until writeback, then issues with forwarded value
    issue(3'b110, 3'd4, 3'd3, 3'd1);
    #1 chk("raw.stall0", 32'(in_ready), 32'd0);
    step();
    chk("raw.drained", 32'(out_valid), 32'd0);
    chk("raw.stall1", 32'(in_ready), 32'd0);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0008;
    #1 chk("raw.fwd_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("raw.sub", 16'h0008, 16'h0005, 3'b110, 3'd4);
    wb_en = 1'b0;
    idle();
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // output hold under backpressure
    out_ready = 1'b0;
    issue(3'b000, 3'd5, 3'd1, 3'd2);
    #1 chk("hold.first_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("hold.and", 16'h0005, 16'h0003, 3'b000, 3'd5);
    issue(3'b001, 3'd6, 3'd2, 3'd1);
    for (int i = 0; i < 5; i++) begin
      #1 chk("hold.in_ready", 32'(in_ready), 32'd0);
      step();
      chk_bundle("hold.stable", 16'h0005, 16'h0003, 3'b000, 3'd5);
    end
    out_ready = 1'b1;
    #1 chk("hold.release_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("hold.or", 16'h0003, 16'h0005, 3'b001, 3'd6);
    idle();
    step();
    chk("hold.drain", 32'(out_valid), 32'd0);

    // illegal opcode: ignores the pending r4 source, pulses once, no bundle
    issue(3'b101, 3'd7, 3'd4, 3'd0);
    #1 chk("ill.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("ill.pulse", 32'(illegal_op), 32'd1);
    chk("ill.valid", 32'(out_valid), 32'd0);
    idle();
    step();
    chk("ill.pulse_end", 32'(illegal_op), 32'd0);
    issue(3'b001, 3'd0, 3'd0, 3'd2);
    #1 chk("or0.in_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("or0", 16'h0000, 16'h0003, 3'b001, 3'd0);
    issue(3'b000, 3'd0, 3'd7, 3'd7);
    #1 chk("ill.r7_not_pending", 32'(in_ready), 32'd1);
    step();
    chk_bundle("r7read", 16'h0000, 16'h0000, 3'b000, 3'd0);
    issue(3'b010, 3'd0, 3'd4, 3'd0);
    #1 chk("ill.r4_still_pending", 32'(in_ready), 32'd0);
    idle();
    step();

    // r0: writes ignored, never forwarded, never stalls
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    issue(3'b010, 3'd0, 3'd0, 3'd0);
    #1 chk("r0.in_ready", 32'(in_ready), 32'd1);
    step();
    chk_bundle("r0.nofwd", 16'h0000, 16'h0000, 3'b010, 3'd0);
    wb_en = 1'b0;
    issue(3'b010, 3'd0, 3'd0, 3'd1);
    step();
    chk_bundle("r0.read", 16'h0000, 16'h0005, 3'b010, 3'd0);
    issue(3'b001, 3'd0, 3'd0, 3'd0);
    #1 chk("r0.nostall", 32'(in_ready), 32'd1);
    step();
    chk_bundle("r0.dep", 16'h0000, 16'h0000, 3'b001, 3'd0);
    idle();
    step();

    // asynchronous reset during a stall clears bundle and scoreboard
    out_ready = 1'b0;
    issue(3'b010, 3'd3, 3'd1, 3'd2);
    step();
    chk_bundle("prerst", 16'h0005, 16'h0003, 3'b010, 3'd3);
    issue(3'b110, 3'd4, 3'd3, 3'd1);
    #1 chk("prerst.stall", 32'(in_ready), 32'd0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.x", 32'(out_x), 32'd0);
    chk("arst.rd", 32'(out_rd), 32'd0);
    idle();
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    issue(3'b110, 3'd4, 3'd3, 3'd1);
    #1 chk("arst.r3_free", 32'(in_ready), 32'd1);
    step();
    chk_bundle("arst.sub", 16'h0000, 16'h0000, 3'b110, 3'd4);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
